// File: rtl/booth_pg_gen.sv
// Radix-4 Booth carry-save multiplier front end; emits prop/gen rows and cin for the final carry chain. Optional macro: BOOTH_PG_EXACT_CIN_EN.
// Latency: out_valid rises 17 edges after accept (16 Booth digits + 1 fold of the negation bits).
// Backpressure: result held in HOLD until out_ready; in_ready low from accept until the output handshake.
module booth_pg_gen #(
    parameter int WIDTH = 32,
    parameter int LSB   = 17,
    parameter int MSB   = 55
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [MSB-LSB:0]     prop,
    output logic [MSB-LSB:0]     gen,
    output logic                 cin,
    output logic                 busy
);

    localparam int PW   = 2 * WIDTH;
    localparam int NDIG = WIDTH / 2;
    localparam int CW   = $clog2(NDIG + 1);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   s_q, c_q, n_q, a_q;
    logic [WIDTH:0]  b_q;
    logic [CW-1:0]   cnt_q;

    logic            fold;
    logic            neg;
    logic [PW-1:0]   mag, pp_raw, pp, nbit, s_nxt, c_nxt, maj, ps;
    logic [CW:0]     shamt;
    logic            cin_raw;

    assign fold  = (cnt_q == CW'(NDIG));
    assign shamt = {cnt_q, 1'b0};

    // b_q holds {b, 1'b0} shifted right two places per digit, so the current triplet is always b_q[2:0]
    always_comb begin
        mag = '0;
        neg = 1'b0;
        case (b_q[2:0])
            3'b001, 3'b010: mag = a_q;
            3'b011:         mag = a_q << 1;
            3'b100: begin
                mag = a_q << 1;
                neg = 1'b1;
            end
            3'b101, 3'b110: begin
                mag = a_q;
                neg = 1'b1;
            end
            default: mag = '0;
        endcase
    end

    // Invert before shifting so the +1 correction lands exactly at column 2i
    assign pp_raw = neg ? ~mag : mag;
    assign pp     = fold ? n_q : (pp_raw << shamt);
    assign nbit   = PW'(neg) << shamt;

    assign maj   = (s_q & c_q) | (s_q & pp) | (c_q & pp);
    assign s_nxt = s_q ^ c_q ^ pp;
    assign c_nxt = {maj[PW-2:0], 1'b0};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (fold)      state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q   <= '0;
            c_q   <= '0;
            n_q   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            cnt_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= {{(PW-WIDTH){a[WIDTH-1]}}, a};
                        b_q   <= {b, 1'b0};
                        s_q   <= '0;
                        c_q   <= '0;
                        n_q   <= '0;
                        cnt_q <= '0;
                    end
                end
                RUN: begin
                    s_q <= s_nxt;
                    c_q <= c_nxt;
                    if (!fold) begin
                        n_q   <= n_q | nbit;
                        b_q   <= b_q >> 2;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BOOTH_PG_EXACT_CIN_EN
    logic [LSB:0] low_sum;
    assign low_sum = {1'b0, s_q[LSB-1:0]} + {1'b0, c_q[LSB-1:0]};
    assign cin_raw = low_sum[LSB];
`else
    // Approximate: only the top low column's carry-generate, ripple from below is dropped
    assign cin_raw = s_q[LSB-1] & c_q[LSB-1];
`endif

    assign ps        = s_q ^ c_q;
    assign out_valid = (state == HOLD);
    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign prop      = out_valid ? ps[MSB:LSB]  : '0;
    assign gen       = out_valid ? s_q[MSB:LSB] : '0;
    assign cin       = out_valid & cin_raw;

endmodule

// File: tb/tb_booth_pg_gen.sv
// Directed and random bench for booth_pg_gen; product bits 55:17 checked through a scoreboard queue.
module tb_booth_pg_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        in_ready, out_valid, cin, busy;
    logic [38:0] prop, gen;

    int checks = 0;
    int errors = 0;
    logic [38:0] exp_q[$];

    booth_pg_gen #(.WIDTH(32), .LSB(17), .MSB(55)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .prop(prop), .gen(gen), .cin(cin), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [38:0] downstream();
        return gen + (prop ^ gen) + 39'(cin);
    endfunction

    task automatic chk_sum(input string tag, input logic [38:0] e);
        logic [38:0] got;
        got = downstream();
        checks++;
`ifdef BOOTH_PG_EXACT_CIN_EN
        assert (got === e) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, e);
        end
`else
        assert (got === e || got === e - 39'd1) else begin
            errors++;
            $error("FAIL %s observed %h expected %h or one less", tag, got, e);
        end
`endif
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge after the output handshake.
    task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input int stall);
        logic signed [63:0] ae, be, p;
        logic [38:0] e, p0, g0;
        logic        c0;
        int          n;
        ae = {{32{av[31]}}, av};
        be = {{32{bv[31]}}, bv};
        p  = ae * be;
        exp_q.push_back(p[55:17]);

        chk("in_ready_idle", 64'(in_ready), 64'd1);
        a = av;
        b = bv;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("in_ready_busy", 64'(in_ready), 64'd0);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("latency", 64'(n), 64'd17);
        if (!out_valid) begin
            void'(exp_q.pop_front());
            return;
        end

        p0 = prop;
        g0 = gen;
        c0 = cin;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            a = ~av;
            b = bv + 32'd1;
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_prop", 64'(prop), 64'(p0));
            chk("hold_gen", 64'(gen), 64'(g0));
            chk("hold_cin", 64'(cin), 64'(c0));
        end
        in_valid = 1'b0;

        e = exp_q.pop_front();
        chk_sum("sum", e);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_valid", 64'(out_valid), 64'd0);
        chk("post_in_ready", 64'(in_ready), 64'd1);
        chk("post_prop_zero", 64'(prop), 64'd0);
        chk("post_gen_zero", 64'(gen), 64'd0);
    endtask

    initial begin
        int seen;
        logic [31:0] ra, rb;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_prop", 64'(prop), 64'd0);
        chk("rst_gen", 64'(gen), 64'd0);
        chk("rst_cin", 64'(cin), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed: 0x10000 * 0x30000 = 3*2^32, bits 55:17 = 0x18000
        do_op(32'h0001_0000, 32'h0003_0000, 0);
        chk("dir_value_1", 64'(downstream()), 64'd0);
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 0);
        do_op(32'h8000_0000, 32'h8000_0000, 0);
        do_op(32'h1234_5678, 32'h8765_4321, 5);
        do_op(32'h7FFF_FFFF, 32'h8000_0000, 2);

        // Reset mid-RUN, then no output may appear and a fresh op must work
        a = 32'd5;
        b = 32'd7;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("midrun_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("no_out_after_rst", 64'(seen), 64'd0);
        do_op(32'd5, 32'd7, 1);

        for (int k = 0; k < 1200; k++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            if ($urandom_range(0, 7) == 0) rb = 32'hFFFF_FFFF;
            do_op(ra, rb, $urandom_range(0, 3));
        end

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
